// File: rtl/cacheline_swap_assembler.sv
// Pairs two half-cacheline buffer-write beats into a full line, checks lane parity,
// applies the byte-order swap captured with the first beat and queues the result.
module cacheline_swap_assembler #(
  parameter int DATA_WIDTH = 512,
  parameter int TAG_WIDTH  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [1:0]                           swap_mode,
  input  logic                                 in_valid,
  input  logic [TAG_WIDTH-1:0]                 in_tag,
  input  logic                                 in_beat,
  input  logic [DATA_WIDTH-1:0]                in_data,
  input  logic [DATA_WIDTH/64-1:0]             in_parity,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [TAG_WIDTH-1:0]                 out_tag,
  output logic [2*DATA_WIDTH-1:0]              out_data,
  output logic                                 out_parity_ok,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_count,
  input  logic                                 err_clear,
  output logic [2:0]                           error
);

  localparam int LANES = DATA_WIDTH / 64;
  localparam int LW    = 2 * DATA_WIDTH;
  localparam int NB    = LW / 8;
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  // Byte groups are aligned powers of two, so in-group reversal is an index XOR.
  function automatic logic [LW-1:0] swap_line(input logic [LW-1:0] line, input logic [1:0] mode);
    logic [LW-1:0] res;
    res = line;
    for (int k = 0; k < NB; k++) begin
      case (mode)
        2'b01:   res[8*k +: 8] = line[8*(k ^ 3) +: 8];
        2'b10:   res[8*k +: 8] = line[8*(k ^ 7) +: 8];
        2'b11:   res[8*k +: 8] = line[8*(NB-1-k) +: 8];
        default: res[8*k +: 8] = line[8*k +: 8];
      endcase
    end
    return res;
  endfunction

  logic                  held_valid;
  logic [TAG_WIDTH-1:0]  held_tag;
  logic                  held_beat;
  logic [DATA_WIDTH-1:0] held_data;
  logic                  held_parity_ok;
  logic [1:0]            held_mode;

  logic [LW-1:0]         mem_data [FIFO_DEPTH];
  logic [TAG_WIDTH-1:0]  mem_tag  [FIFO_DEPTH];
  logic                  mem_ok   [FIFO_DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;

  logic          beat_ok;
  logic          same_tag;
  logic          complete;
  logic          duplicate;
  logic          mismatch;
  logic          pop;
  logic          push;
  logic          overflow;
  logic [LW-1:0] merged;
  logic [LW-1:0] swapped;

  // Lane i is counted from the MSB end of the beat, matching the bit-0-MSB numbering.
  always_comb begin
    beat_ok = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      if (!(^{in_data[DATA_WIDTH-1-64*i -: 64], in_parity[i]})) beat_ok = 1'b0;
    end
  end

  always_comb begin
    same_tag  = (held_tag == in_tag);
    complete  = in_valid && held_valid && same_tag && (in_beat != held_beat);
    duplicate = in_valid && held_valid && same_tag && (in_beat == held_beat);
    mismatch  = in_valid && held_valid && !same_tag;
    pop       = out_valid && out_ready;
    push      = complete && ((fifo_count != FULL_COUNT) || pop);
    overflow  = complete && (fifo_count == FULL_COUNT) && !pop;
    merged    = in_beat ? {held_data, in_data} : {in_data, held_data};
    swapped   = swap_line(merged, held_mode);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      held_valid     <= 1'b0;
      held_tag       <= '0;
      held_beat      <= 1'b0;
      held_data      <= '0;
      held_parity_ok <= 1'b0;
      held_mode      <= 2'b00;
    end else if (in_valid) begin
      if (!held_valid || mismatch) begin
        held_valid     <= 1'b1;
        held_tag       <= in_tag;
        held_beat      <= in_beat;
        held_data      <= in_data;
        held_parity_ok <= beat_ok;
        held_mode      <= swap_mode;
      end else if (complete) begin
        held_valid <= 1'b0;
      end else begin
        held_data      <= in_data;
        held_parity_ok <= beat_ok;
      end
    end
  end

  // Storage is not reset; the outputs are masked by out_valid instead.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_data[wr_ptr] <= swapped;
      mem_tag[wr_ptr]  <= held_tag;
      mem_ok[wr_ptr]   <= held_parity_ok && beat_ok;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // A new event in the same cycle as err_clear leaves its bit set.
  always_ff @(posedge clock) begin
    if (reset) begin
      error <= 3'b000;
    end else begin
      error <= (err_clear ? 3'b000 : error) |
               {overflow, duplicate || mismatch, in_valid && !beat_ok};
    end
  end

  always_comb begin
    out_valid     = (fifo_count != '0);
    out_data      = out_valid ? mem_data[rd_ptr] : '0;
    out_tag       = out_valid ? mem_tag[rd_ptr]  : '0;
    out_parity_ok = out_valid ? mem_ok[rd_ptr]   : 1'b0;
  end

endmodule

// File: tb/tb_cacheline_swap_assembler.sv
// Directed bench for cacheline_swap_assembler: stimulus pushes expected lines into a
// scoreboard queue, and a negedge monitor pops and compares every delivered line.
module tb_cacheline_swap_assembler;

  logic          clock = 1'b0;
  logic          reset;
  logic [1:0]    swap_mode;
  logic          in_valid;
  logic [7:0]    in_tag;
  logic          in_beat;
  logic [511:0]  in_data;
  logic [7:0]    in_parity;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_tag;
  logic [1023:0] out_data;
  logic          out_parity_ok;
  logic [2:0]    fifo_count;
  logic          err_clear;
  logic [2:0]    error;

  typedef struct packed {
    logic [7:0]    tag;
    logic [1023:0] data;
    logic          ok;
  } exp_t;

  exp_t sb_q[$];
  int   assert_count = 0;
  int   fail_count   = 0;

  cacheline_swap_assembler #(.DATA_WIDTH(512), .TAG_WIDTH(8), .FIFO_DEPTH(4)) dut (
    .clock(clock), .reset(reset), .swap_mode(swap_mode), .in_valid(in_valid),
    .in_tag(in_tag), .in_beat(in_beat), .in_data(in_data), .in_parity(in_parity),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
    .out_data(out_data), .out_parity_ok(out_parity_ok), .fifo_count(fifo_count),
    .err_clear(err_clear), .error(error)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  function automatic logic [7:0] gen_par(input logic [511:0] d);
    logic [7:0] p;
    for (int i = 0; i < 8; i++) p[i] = ~^d[511-64*i -: 64];
    return p;
  endfunction

  function automatic logic [511:0] inc_beat(input int base);
    logic [511:0] d;
    for (int k = 0; k < 64; k++) d[511-8*k -: 8] = 8'(base + k);
    return d;
  endfunction

  // Byte k counts from the MSB end; the pattern value of byte k is k.
  function automatic logic [1023:0] inc_expected(input logic [1:0] mode);
    logic [1023:0] l;
    int src;
    for (int k = 0; k < 128; k++) begin
      case (mode)
        2'b01:   src = 4 * (k / 4) + 3 - (k % 4);
        2'b10:   src = 8 * (k / 8) + 7 - (k % 8);
        2'b11:   src = 127 - k;
        default: src = k;
      endcase
      l[1023-8*k -: 8] = 8'(src);
    end
    return l;
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] tag, input logic beat, input logic [511:0] data,
                               input logic [7:0] par, input logic [1:0] mode);
    in_tag    = tag;
    in_beat   = beat;
    in_data   = data;
    in_parity = par;
    swap_mode = mode;
    in_valid  = 1'b1;
    @(posedge clock);
    #1;
    in_valid  = 1'b0;
  endtask

  // The second beat carries a different swap_mode so the captured mode is exercised.
  task automatic send_pair(input logic [7:0] tag, input logic [511:0] b0, input logic [511:0] b1,
                           input logic [1:0] mode, input logic rev, input logic flip3);
    logic [7:0] p0, p1;
    p0 = gen_par(b0);
    p1 = gen_par(b1);
    if (flip3) p1[3] = ~p1[3];
    if (!rev) begin
      applyStimulus(tag, 1'b0, b0, p0, mode);
      applyStimulus(tag, 1'b1, b1, p1, ~mode);
    end else begin
      applyStimulus(tag, 1'b1, b1, p1, mode);
      applyStimulus(tag, 1'b0, b0, p0, ~mode);
    end
  endtask

  task automatic push_expect(input logic [7:0] tag, input logic [1023:0] data, input logic ok);
    exp_t e;
    e.tag  = tag;
    e.data = data;
    e.ok   = ok;
    sb_q.push_back(e);
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        assert_count++;
        fail_count++;
        $display("[TB] FAIL unexpected_line: got tag %h, expected no line", out_tag);
      end else begin
        e = sb_q.pop_front();
        checkOutput("line_tag", 64'(out_tag), 64'(e.tag));
        checkOutput("line_parity_ok", 64'(out_parity_ok), 64'(e.ok));
        assert_count++;
        if (out_data !== e.data) begin
          fail_count++;
          for (int i = 0; i < 16; i++) begin
            if (out_data[1023-64*i -: 64] !== e.data[1023-64*i -: 64]) begin
              $display("[TB] FAIL line_data tag %h lane %0d: got %h, expected %h", e.tag, i,
                       out_data[1023-64*i -: 64], e.data[1023-64*i -: 64]);
              break;
            end
          end
        end
      end
    end
  end

  initial begin
    logic [1023:0] tmp;
    reset = 1'b1; swap_mode = 2'b00; in_valid = 1'b0; in_tag = '0; in_beat = 1'b0;
    in_data = '0; in_parity = '0; out_ready = 1'b1; err_clear = 1'b0;
    wait_cycles(2);
    @(negedge clock);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_fifo_count", 64'(fifo_count), 64'd0);
    checkOutput("reset_error", 64'(error), 64'd0);
    checkOutput("reset_out_tag", 64'(out_tag), 64'd0);
    checkOutput("reset_out_parity_ok", 64'(out_parity_ok), 64'd0);
    checkOutput("reset_out_data_zero", 64'(out_data != '0), 64'd0);
    wait_cycles(1);
    reset = 1'b0;
    wait_cycles(1);

    $display("[TB] mode 00 basic line");
    push_expect(8'h05, {{64{8'h11}}, {64{8'h22}}}, 1'b1);
    send_pair(8'h05, {64{8'h11}}, {64{8'h22}}, 2'b00, 1'b0, 1'b0);
    @(negedge clock);
    checkOutput("latency_out_valid", 64'(out_valid), 64'd1);
    checkOutput("basic_out_tag", 64'(out_tag), 64'h05);
    checkOutput("basic_upper_lane", out_data[1023:960], {8{8'h11}});
    checkOutput("basic_lower_lane", out_data[63:0], {8{8'h22}});
    checkOutput("basic_error", 64'(error), 64'd0);
    wait_cycles(1);

    $display("[TB] swap modes with incrementing pattern");
    for (int m = 1; m < 4; m++) begin
      push_expect(8'(8'h10 + m), inc_expected(2'(m)), 1'b1);
      send_pair(8'(8'h10 + m), inc_beat(0), inc_beat(64), 2'(m), 1'b0, 1'b0);
      @(negedge clock);
      tmp = out_data;
      case (m)
        1: checkOutput("mode01_first_word", 64'(tmp[1023:992]), 64'h03020100);
        2: checkOutput("mode10_first_dword", tmp[1023:960], 64'h0706050403020100);
        default: begin
          checkOutput("mode11_first_byte", 64'(tmp[1023:1016]), 64'h7F);
          checkOutput("mode11_last_byte", 64'(tmp[7:0]), 64'h00);
        end
      endcase
      wait_cycles(1);
    end
    push_expect(8'h20, inc_expected(2'b11), 1'b1);
    send_pair(8'h20, inc_beat(0), inc_beat(64), 2'b11, 1'b1, 1'b0);
    push_expect(8'h21, inc_expected(2'b01), 1'b1);
    send_pair(8'h21, inc_beat(0), inc_beat(64), 2'b01, 1'b1, 1'b0);
    wait_cycles(2);

    $display("[TB] parity failure on beat 1 lane 3");
    push_expect(8'h33, {{64{8'h11}}, {64{8'h22}}}, 1'b0);
    send_pair(8'h33, {64{8'h11}}, {64{8'h22}}, 2'b00, 1'b0, 1'b1);
    @(negedge clock);
    checkOutput("parity_out_parity_ok", 64'(out_parity_ok), 64'd0);
    checkOutput("parity_error_set", 64'(error), 64'b001);
    wait_cycles(3);
    @(negedge clock);
    checkOutput("parity_error_sticky", 64'(error), 64'b001);
    checkOutput("parity_line_popped", 64'(out_valid), 64'd0);
    wait_cycles(1);
    err_clear = 1'b1;
    wait_cycles(1);
    err_clear = 1'b0;
    @(negedge clock);
    checkOutput("parity_error_cleared", 64'(error), 64'b000);
    wait_cycles(1);

    $display("[TB] tag mismatch discards partial");
    applyStimulus(8'h01, 1'b0, {64{8'hA1}}, gen_par({64{8'hA1}}), 2'b00);
    push_expect(8'h02, {{64{8'hB2}}, {64{8'hC3}}}, 1'b1);
    send_pair(8'h02, {64{8'hB2}}, {64{8'hC3}}, 2'b00, 1'b0, 1'b0);
    @(negedge clock);
    checkOutput("mismatch_error", 64'(error), 64'b010);
    wait_cycles(3);
    err_clear = 1'b1;
    wait_cycles(1);
    err_clear = 1'b0;

    $display("[TB] overflow with consumer stalled");
    out_ready = 1'b0;
    for (int n = 0; n < 5; n++) begin
      if (n < 4) push_expect(8'(8'h40 + n), {{64{8'(n)}}, {64{8'(8'hF0 + n)}}}, 1'b1);
      send_pair(8'(8'h40 + n), {64{8'(n)}}, {64{8'(8'hF0 + n)}}, 2'b00, 1'b0, 1'b0);
    end
    @(negedge clock);
    checkOutput("overflow_fifo_count", 64'(fifo_count), 64'd4);
    checkOutput("overflow_error", 64'(error), 64'b100);
    checkOutput("overflow_head_stable", 64'(out_tag), 64'h40);
    wait_cycles(1);
    err_clear = 1'b1;
    wait_cycles(1);
    err_clear = 1'b0;
    push_expect(8'h45, {{64{8'h55}}, {64{8'h66}}}, 1'b1);
    applyStimulus(8'h45, 1'b0, {64{8'h55}}, gen_par({64{8'h55}}), 2'b00);
    out_ready = 1'b1;
    applyStimulus(8'h45, 1'b1, {64{8'h66}}, gen_par({64{8'h66}}), 2'b00);
    out_ready = 1'b0;
    @(negedge clock);
    checkOutput("full_push_pop_count", 64'(fifo_count), 64'd4);
    checkOutput("full_push_pop_error", 64'(error), 64'b000);
    wait_cycles(1);
    out_ready = 1'b1;
    wait_cycles(6);
    @(negedge clock);
    checkOutput("drain_fifo_count", 64'(fifo_count), 64'd0);
    wait_cycles(1);

    $display("[TB] reset with held beat and queued lines");
    out_ready = 1'b0;
    send_pair(8'h50, {64{8'h01}}, {64{8'h02}}, 2'b00, 1'b0, 1'b0);
    send_pair(8'h51, {64{8'h03}}, {64{8'h04}}, 2'b00, 1'b0, 1'b0);
    applyStimulus(8'h77, 1'b0, {64{8'h07}}, gen_par({64{8'h07}}), 2'b00);
    reset = 1'b1;
    wait_cycles(1);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("post_reset_fifo_count", 64'(fifo_count), 64'd0);
    checkOutput("post_reset_out_valid", 64'(out_valid), 64'd0);
    wait_cycles(1);
    out_ready = 1'b1;
    applyStimulus(8'h77, 1'b1, {64{8'h08}}, gen_par({64{8'h08}}), 2'b00);
    wait_cycles(3);
    @(negedge clock);
    checkOutput("orphan_beat_out_valid", 64'(out_valid), 64'd0);
    checkOutput("orphan_beat_fifo_count", 64'(fifo_count), 64'd0);
    checkOutput("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
